coin_start_sequencer: RTL and testbench

Serialises coin and start requests from the keyboard/joystick decode into clean, fixed-width pulses on the arcade core's coin/start inputs. Rising edges on four request lines are queued per source, granted one at a time by a round-robin arbiter, and each grant drives exactly one output pulse followed by a mandatory quiet gap. It sits in the top level between the `kbjoy`/joystick decode and the core's `P1_CSJUDLR`/`P2_CSJUDLR` coin and start bits, all on `clk_sys`.

---
 rtl/coin_start_sequencer.sv | 147 ++++++++++++++
 tb/tb_coin_start_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : coin_start_sequencer
//  Description : Turns rising edges on four coin/start request lines into
//                fixed-width, non-overlapping pulses. Edges are queued per
//                source (2-bit saturating), a round-robin arbiter picks one
//                source at a time, and every pulse is followed by a quiet gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_start_sequencer #(
    parameter int PULSE_CYC = 1800000,
    parameter int GAP_CYC   = 1800000,
    parameter int CNT_W     = 21
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] pulse_o,
    output logic       busy,
    output logic [1:0] grant_idx,
    output logic       overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] c_GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_prev;
    logic [3:0][1:0]  r_pend;

    logic [3:0]       w_edge;
    logic [3:0]       w_dec;
    logic [3:0]       w_ovf;
    logic             w_any;
    logic             w_grant;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;

    assign w_edge  = req & ~r_prev;
    assign w_grant = (r_state == S_IDLE) && w_any;
    assign w_dec   = w_grant ? (4'b0001 << w_win) : 4'b0000;

    // Previous request levels; reset high so lines held through reset are ignored
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_prev <= 4'b1111;
        end else begin
            r_prev <= req;
        end
    end

    // Round-robin search starting one past the last granted source
    always_comb begin
        w_any = 1'b0;
        w_win = grant_idx;
        w_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = grant_idx + 2'(k);
            if (!w_any && (r_pend[w_idx] != 2'd0)) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // An edge on a saturated source that is not being granted this cycle is lost
    always_comb begin
        w_ovf = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_ovf[i] = w_edge[i] & ~w_dec[i] & (r_pend[i] == 2'd3);
        end
    end

    // Per-source pending counters: edge increments, grant decrements, both cancel
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pend   <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_edge[i] && !w_dec[i]) begin
                    if (r_pend[i] != 2'd3) begin
                        r_pend[i] <= r_pend[i] + 2'd1;
                    end
                end else if (w_dec[i] && !w_edge[i]) begin
                    r_pend[i] <= r_pend[i] - 2'd1;
                end
            end
            overflow <= |w_ovf;
        end
    end

    // Grant / pulse / gap sequencing with registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            pulse_o   <= 4'b0000;
            busy      <= 1'b0;
            grant_idx <= 2'd3;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        pulse_o   <= 4'b0001 << w_win;
                        grant_idx <= w_win;
                        r_cnt     <= c_PULSE_LD;
                        r_state   <= S_PULSE;
                        busy      <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        pulse_o <= 4'b0000;
                        r_cnt   <= c_GAP_LD;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    pulse_o <= 4'b0000;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_start_sequencer
//  Description : Directed and randomized bench for coin_start_sequencer with
//                a time-based reference model (grant schedule + queues).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_start_sequencer;

    localparam int P = 4;
    localparam int G = 3;

    logic       clk_sys;
    logic       reset;
    logic [3:0] req;
    logic [3:0] pulse_o;
    logic       busy;
    logic [1:0] grant_idx;
    logic       overflow;

    int n_vec;
    int n_err;

    // reference model state
    int         cyc;
    int         m_pend [4];
    logic [3:0] m_prev;
    int         m_last;
    bit         m_has;
    int         m_gcyc;
    int         m_next_free;
    logic [3:0] exp_pulse;
    logic       exp_busy;
    logic       exp_ovf;

    coin_start_sequencer #(
        .PULSE_CYC(P),
        .GAP_CYC  (G),
        .CNT_W    (4)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .req      (req),
        .pulse_o  (pulse_o),
        .busy     (busy),
        .grant_idx(grant_idx),
        .overflow (overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_prev      = 4'b1111;
        m_last      = 3;
        m_has       = 1'b0;
        m_gcyc      = 0;
        m_next_free = 0;
        exp_pulse   = 4'b0000;
        exp_busy    = 1'b0;
        exp_ovf     = 1'b0;
    endtask

    task automatic check_outputs();
        chk("pulse_o",   pulse_o,   exp_pulse);
        chk("busy",      busy,      exp_busy);
        chk("grant_idx", grant_idx, m_last[1:0]);
        chk("overflow",  overflow,  exp_ovf);
        chk("onehot",    $onehot0(pulse_o), 1'b1);
    endtask

    // Apply one request vector for one clock and compare against the model
    task automatic step(input logic [3:0] r);
        logic [3:0] e;
        bit         g;
        int         w;
        int         s;
        bit         dec;
        @(negedge clk_sys);
        req = r;
        @(posedge clk_sys);
        cyc++;
        e      = r & ~m_prev;
        m_prev = r;
        g      = 1'b0;
        w      = m_last;
        if (cyc >= m_next_free) begin
            for (int k = 1; k <= 4; k++) begin
                s = (m_last + k) % 4;
                if (!g && m_pend[s] > 0) begin
                    g = 1'b1;
                    w = s;
                end
            end
        end
        exp_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dec = g && (w == i);
            if (e[i] && !dec) begin
                if (m_pend[i] == 3) exp_ovf = 1'b1;
                else                m_pend[i]++;
            end else if (dec && !e[i]) begin
                m_pend[i]--;
            end
        end
        if (g) begin
            m_last      = w;
            m_has       = 1'b1;
            m_gcyc      = cyc;
            m_next_free = cyc + P + G + 1;
        end
        exp_pulse = (m_has && (cyc - m_gcyc) < P) ? (4'b0001 << m_last) : 4'b0000;
        exp_busy  = m_has && ((cyc - m_gcyc) < (P + G));
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000);
    endtask

    initial begin
        logic [3:0] rr;
        int         guard;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        req   = 4'b0000;
        reset = 1'b1;
        model_reset();

        // reset state while clocks run
        repeat (3) @(posedge clk_sys);
        #1;
        check_outputs();
        #2;
        reset = 1'b0;

        // single request on start1, held high
        idle(5);
        for (int i = 0; i < 20; i++) step(4'b0100);
        idle(5);

        // all four at once: fair order 0,1,2,3
        for (int i = 0; i < 40; i++) step(4'b1111);
        idle(5);

        // queue saturation on coin1: six rising edges in quick succession
        for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 4'b0001 : 4'b0000);
        idle(40);

        // edge on coin2 in the same cycle as its grant
        step(4'b0001);
        step(4'b0011);
        guard = 0;
        while ((cyc + 1 < m_next_free) && (guard < 20)) begin
            step(4'b0000);
            guard++;
        end
        n_vec++;
        if (guard >= 20) begin
            n_err++;
            $error("FAIL grant_wait: observed timeout expected grant slot");
        end
        step(4'b0010);
        idle(25);

        // reset during second cycle of a pulse with two more requests queued
        step(4'b0001);
        step(4'b0111);
        step(4'b0111);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(4'b0111);
        idle(3);

        // held start2 line gives a single pulse
        for (int i = 0; i < 50; i++) step(4'b1000);
        idle(10);

        // randomized request traffic
        rr = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
            step(rr);
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
